rf_wport_arbiter: RTL and testbench
===================================

# rf_wport_arbiter

Arbiter and scheduler for the single write port of the 32x32 register file. It shares the port between the W-stage writeback and the multi-cycle MDU result path, with W-stage priority. Deferred MDU results are buffered in a small in-order queue, and a per-register pending mask is exported to the hazard unit. The block sits between the W stage/MDU and the RF write inputs (RF_wr, A3, WD, PC, Instr).

## Interface
- DEPTH, 2, MDU result queue entries; power of 2, minimum 2
- STARVE_MAX, 4, consecutive cycles a live queue head may be blocked by W before w_hold is raised
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 = in reset
- w_wr  in  1  W-stage write request
- w_a3  in  5  W-stage destination register
- w_wd / w_pc / w_instr  in  32 each  W-stage write data, PC, instruction
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  queue can accept an MDU result
- mdu_a3  in  5  MDU destination register
- mdu_wd / mdu_pc / mdu_instr  in  32 each  MDU data, PC, instruction
- rf_wr  out  1  drives RF_wr
- rf_a3  out  5  drives A3
- rf_wd / rf_pc / rf_instr  out  32 each  drive WD, PC, Instr
- rf_src  out  1  0 = W stage, 1 = MDU (queue or bypass); valid only when rf_wr=1
- busy_mask  out  32  bit r=1: a live queued entry targets $r; bit 0 always 0
- w_hold  out  1  request to hazard unit: insert a W-stage bubble

## Operation
- W-active = w_wr && w_a3!=0. Writes to $0 never assert rf_wr from either source.
- MDU accept = mdu_valid && mdu_ready, where mdu_ready = (count < DEPTH). An accepted result with mdu_a3==0 is acknowledged and discarded.
- Port grant, evaluated in this priority order:
  1. W-active: port gets W fields, rf_src=0.
  2. Else, queue head live: port gets head fields, rf_src=1, head popped.
  3. Else, queue empty and an MDU accept with a3!=0: bypass. Port gets mdu fields, rf_src=1, nothing enqueued.
  4. Else rf_wr=0.
- Enqueue: an accepted MDU result with a3!=0 that is not bypassed goes to the tail. Push and pop in the same cycle are legal. count changes by push-pop.
- Kill rule (preserves program order):
  - When W-active writes $r, every entry present in the queue at cycle start with a3==r is marked killed.
  - A same-cycle push to $r is not killed.
  - A killed head is popped in any cycle, including W-active cycles, without using the port.
- busy_mask = OR over valid, non-killed entries of onehot(a3), derived from registered state only.
- Starvation counter:
  - Increments each cycle the head is live and W-active blocks it.
  - Clears on any pop or when the queue is empty.
  - Saturates at STARVE_MAX.
  - w_hold = (counter == STARVE_MAX), combinational from the counter only.
- Reset (reset=0, asynchronous): pointers, count, valid/kill bits and counter cleared. While reset=0: rf_wr=0, mdu_ready=0, busy_mask=0, w_hold=0, rf_src=0, data outputs don't-care.

## Timing
- W path: zero latency, combinational from w_* to rf_*. RF commits on the same rising edge.
- MDU bypass: zero latency.
- Queued entry: written no earlier than the cycle after the push, at the first cycle with W idle.
- Busy bit: sets at the edge that pushes and clears at the edge that pops or kills.
- mdu_ready depends on registered count only; there is no combinational path from any input.
- mdu_ready is 1 from the first cycle after reset release.
- With the queue full and W idle: pop this cycle, mdu_ready=1 next cycle.
- w_hold rises the cycle after the STARVE_MAXth blocked cycle. It falls the cycle after the head drains.
- Counter wrap: not possible (saturates). Pointers wrap modulo DEPTH.

## Test plan
- Reset with w_wr=1, w_a3=5, then release -> rf_wr=0 during reset; then rf_wr=1, rf_a3=5, rf_src=0; mdu_ready=1.
- Queue empty, W idle, MDU offers $8=0x1234 -> same cycle rf_wr=1, rf_a3=8, rf_wd=0x1234, rf_src=1; busy_mask stays 0.
- W writes $3 for 3 cycles while MDU pushes $9 then $10 -> mdu_ready=0 after two pushes; busy_mask=0x600. The first W-idle cycle writes $9, the next writes $10; busy_mask ends at 0.
- Queue holds $7, then W-active writes $7=0xAA -> entry killed, busy_mask bit 7 clears, the $7 value is never written by the MDU, and the RF holds 0xAA.
- W-active every cycle with a live head, STARVE_MAX=4 -> w_hold=1 in cycle 5. W then idles one cycle -> head written, w_hold=0 the next cycle.
- MDU offers $0 with the queue empty -> accepted, rf_wr=0, count stays 0.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// Write-port arbiter for the 32x32 register file: W stage has priority, MDU results
// bypass when the port is free or wait in a small in-order queue with kill tracking.
module rf_wport_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_wr,
  input  logic [4:0]  w_a3,
  input  logic [31:0] w_wd,
  input  logic [31:0] w_pc,
  input  logic [31:0] w_instr,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_a3,
  input  logic [31:0] mdu_wd,
  input  logic [31:0] mdu_pc,
  input  logic [31:0] mdu_instr,
  output logic        rf_wr,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic [31:0] rf_pc,
  output logic [31:0] rf_instr,
  output logic        rf_src,
  output logic [31:0] busy_mask,
  output logic        w_hold
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  logic [4:0]       q_a3    [DEPTH];
  logic [31:0]      q_wd    [DEPTH];
  logic [31:0]      q_pc    [DEPTH];
  logic [31:0]      q_instr [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [DEPTH-1:0] q_kill;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve;

  logic w_act;
  logic q_empty;
  logic head_vld;
  logic head_kill;
  logic head_live;
  logic ready_int;
  logic mdu_acc;
  logic mdu_live;
  logic bypass;
  logic pop;
  logic push;

  assign w_act     = w_wr && (w_a3 != 5'd0);
  assign q_empty   = (count == '0);
  assign head_vld  = q_vld[rd_ptr];
  assign head_kill = q_kill[rd_ptr];
  assign head_live = head_vld && !head_kill;
  assign ready_int = (count < CNT_W'(DEPTH));
  assign mdu_acc   = reset && mdu_valid && ready_int;
  assign mdu_live  = mdu_acc && (mdu_a3 != 5'd0);
  assign bypass    = !w_act && q_empty && mdu_live;
  // A killed head leaves without the port, even while W owns it.
  assign pop       = reset && head_vld && (head_kill || !w_act);
  assign push      = mdu_live && !bypass;

  assign mdu_ready = reset && ready_int;
  assign w_hold    = (starve == STV_W'(STARVE_MAX));

  always_comb begin
    rf_wr    = 1'b0;
    rf_src   = 1'b0;
    rf_a3    = w_a3;
    rf_wd    = w_wd;
    rf_pc    = w_pc;
    rf_instr = w_instr;
    if (reset) begin
      if (w_act) begin
        rf_wr = 1'b1;
      end else if (head_live) begin
        rf_wr    = 1'b1;
        rf_src   = 1'b1;
        rf_a3    = q_a3[rd_ptr];
        rf_wd    = q_wd[rd_ptr];
        rf_pc    = q_pc[rd_ptr];
        rf_instr = q_instr[rd_ptr];
      end else if (bypass) begin
        rf_wr    = 1'b1;
        rf_src   = 1'b1;
        rf_a3    = mdu_a3;
        rf_wd    = mdu_wd;
        rf_pc    = mdu_pc;
        rf_instr = mdu_instr;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i] && !q_kill[i]) busy_mask[q_a3[i]] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  // Queue control state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      q_vld  <= '0;
      q_kill <= '0;
      starve <= '0;
    end else begin
      // Only entries already queued are killed; a same-cycle push lands in an empty slot.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_act && q_vld[i] && (q_a3[i] == w_a3)) q_kill[i] <= 1'b1;
      end
      if (pop) begin
        q_vld[rd_ptr]  <= 1'b0;
        q_kill[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        q_vld[wr_ptr]  <= 1'b1;
        q_kill[wr_ptr] <= 1'b0;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (pop || q_empty) begin
        starve <= '0;
      end else if (head_live && w_act && !w_hold) begin
        starve <= starve + STV_W'(1);
      end
    end
  end

  // Queue payload storage
  always_ff @(posedge clk) begin
    if (push) begin
      q_a3[wr_ptr]    <= mdu_a3;
      q_wd[wr_ptr]    <= mdu_wd;
      q_pc[wr_ptr]    <= mdu_pc;
      q_instr[wr_ptr] <= mdu_instr;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scoreboard bench for rf_wport_arbiter: directed scenarios then randomized traffic,
// checked against a queue-based reference model of the write-port rules.
module tb_rf_wport_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        w_wr = 1'b0;
  logic [4:0]  w_a3 = '0;
  logic [31:0] w_wd = '0, w_pc = '0, w_instr = '0;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_a3 = '0;
  logic [31:0] mdu_wd = '0, mdu_pc = '0, mdu_instr = '0;
  logic        rf_wr;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd, rf_pc, rf_instr;
  logic        rf_src;
  logic [31:0] busy_mask;
  logic        w_hold;

  rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .w_wr(w_wr), .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc), .w_instr(w_instr),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_a3(mdu_a3),
    .mdu_wd(mdu_wd), .mdu_pc(mdu_pc), .mdu_instr(mdu_instr),
    .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_pc(rf_pc), .rf_instr(rf_instr),
    .rf_src(rf_src), .busy_mask(busy_mask), .w_hold(w_hold)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        killed;
  } ent_t;

  typedef struct packed {
    logic        wr;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        src;
    logic [31:0] busy;
    logic        ready;
    logic        hold;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  int   starve = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference model: computes this cycle's expected outputs, then advances to post-edge state.
  task automatic model_step();
    exp_t e;
    ent_t n;
    bit   wact, acc, live, byp, pop;
    e = '0;
    if (!reset) begin
      mq.delete();
      starve = 0;
      sb.push_back(e);
      return;
    end
    wact    = w_wr && (w_a3 != 5'd0);
    e.ready = (mq.size() < DEPTH);
    e.hold  = (starve == STARVE_MAX);
    foreach (mq[i]) if (!mq[i].killed) e.busy[mq[i].a3] = 1'b1;
    e.busy[0] = 1'b0;
    acc  = mdu_valid && e.ready;
    live = (mq.size() > 0) && !mq[0].killed;
    byp  = 1'b0;
    if (wact) begin
      e.wr = 1; e.src = 0; e.a3 = w_a3; e.wd = w_wd; e.pc = w_pc; e.instr = w_instr;
    end else if (live) begin
      e.wr = 1; e.src = 1; e.a3 = mq[0].a3; e.wd = mq[0].wd; e.pc = mq[0].pc; e.instr = mq[0].instr;
    end else if (mq.size() == 0 && acc && mdu_a3 != 5'd0) begin
      byp = 1'b1;
      e.wr = 1; e.src = 1; e.a3 = mdu_a3; e.wd = mdu_wd; e.pc = mdu_pc; e.instr = mdu_instr;
    end
    pop = (mq.size() > 0) && (mq[0].killed || !wact);
    if (pop || mq.size() == 0) starve = 0;
    else if (live && wact && starve < STARVE_MAX) starve++;
    if (wact) foreach (mq[i]) if (mq[i].a3 == w_a3) mq[i].killed = 1'b1;
    if (pop) void'(mq.pop_front());
    if (acc && mdu_a3 != 5'd0 && !byp) begin
      n.a3 = mdu_a3; n.wd = mdu_wd; n.pc = mdu_pc; n.instr = mdu_instr; n.killed = 1'b0;
      mq.push_back(n);
    end
    sb.push_back(e);
  endtask

  task automatic cyc(input bit rst, input bit ww, input logic [4:0] wa, input logic [31:0] wd,
                     input bit mv, input logic [4:0] ma, input logic [31:0] md);
    @(negedge clk);
    reset     = rst;
    w_wr      = ww;
    w_a3      = wa;
    w_wd      = wd;
    w_pc      = $urandom;
    w_instr   = $urandom;
    mdu_valid = mv;
    mdu_a3    = ma;
    mdu_wd    = md;
    mdu_pc    = $urandom;
    mdu_instr = $urandom;
    model_step();
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rf_wr", 32'(rf_wr), 32'(e.wr));
        if (e.wr) begin
          chk("rf_a3", 32'(rf_a3), 32'(e.a3));
          chk("rf_wd", rf_wd, e.wd);
          chk("rf_pc", rf_pc, e.pc);
          chk("rf_instr", rf_instr, e.instr);
          chk("rf_src", 32'(rf_src), 32'(e.src));
        end
        chk("busy_mask", busy_mask, e.busy);
        chk("mdu_ready", 32'(mdu_ready), 32'(e.ready));
        chk("w_hold", 32'(w_hold), 32'(e.hold));
      end
    end
  end

  logic [4:0] regs [8] = '{5'd0, 5'd1, 5'd3, 5'd7, 5'd9, 5'd10, 5'd31, 5'd3};

  initial begin
    // Reset with a pending W write, then release
    cyc(0, 1, 5, 32'h55, 0, 0, 0);
    cyc(0, 1, 5, 32'h55, 0, 0, 0);
    cyc(1, 1, 5, 32'h55, 0, 0, 0);
    // Bypass on empty queue
    cyc(1, 0, 0, 0, 1, 8, 32'h1234);
    // Fill the queue behind W, then drain in order
    cyc(1, 1, 3, 32'h3, 1, 9, 32'h99);
    cyc(1, 1, 3, 32'h3, 1, 10, 32'h1010);
    cyc(1, 1, 3, 32'h3, 1, 11, 32'hbad);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Kill a queued $7 by a younger W write
    cyc(1, 1, 3, 32'h3, 1, 7, 32'h77);
    cyc(1, 1, 7, 32'hAA, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Starvation: push then keep W busy
    cyc(1, 1, 3, 32'h3, 1, 12, 32'hC);
    repeat (5) cyc(1, 1, 3, 32'h3, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // MDU result to $0 is swallowed
    cyc(1, 0, 0, 0, 1, 0, 32'hdead);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Randomized traffic with varying W pressure and an occasional reset
    for (int n = 0; n < 3000; n++) begin
      int wpct;
      bit ww, mv, rs;
      case ((n / 400) % 3)
        0:       wpct = 20;
        1:       wpct = 50;
        default: wpct = 90;
      endcase
      ww = ($urandom_range(0, 99) < wpct);
      mv = ($urandom_range(0, 99) < 50);
      rs = ($urandom_range(0, 499) != 0);
      cyc(rs, ww, regs[$urandom_range(0, 7)], $urandom, mv, regs[$urandom_range(0, 7)], $urandom);
    end
    @(negedge clk);
    #5;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
